// File: rtl/ahb_apb_bridge_mp.sv
// AHB-Lite slave to multi-slot APB3 master bridge.
// One transfer outstanding; the slot is picked by a 4-bit HADDR field.
// A slot past NUM_SLAVES, a slave error or a wait timeout all produce the
// two-cycle AHB ERROR response.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   S_IDLE   | no transfer; HREADYOUT=1, ready to accept
//   S_SETUP  | APB setup phase, PSEL high, PENABLE low
//   S_ACCESS | APB access phase, waiting on PREADY of the selected slot
//   S_ERR1   | first ERROR cycle, HREADYOUT=0, HRESP=1, APB idle
//   S_ERR2   | second ERROR cycle, HREADYOUT=1, HRESP=1, may accept
module ahb_apb_bridge_mp #(
   parameter int NUM_SLAVES = 16,
   parameter int SLOT_LSB   = 8,
   parameter int PADDR_W    = 32,
   parameter int TIMEOUT    = 255
) (
   input  logic                     HCLK,
   input  logic                     HRESET,
   input  logic                     HSEL,
   input  logic [1:0]               HTRANS,
   input  logic                     HWRITE,
   input  logic [31:0]              HADDR,
   input  logic [31:0]              HWDATA,
   input  logic                     HREADYIN,
   output logic                     HREADYOUT,
   output logic                     HRESP,
   output logic [31:0]              HRDATA,
   output logic [NUM_SLAVES-1:0]    PSEL,
   output logic                     PENABLE,
   output logic                     PWRITE,
   output logic [PADDR_W-1:0]       PADDR,
   output logic [31:0]              PWDATA,
   input  logic [32*NUM_SLAVES-1:0] PRDATA,
   input  logic [NUM_SLAVES-1:0]    PREADY,
   input  logic [NUM_SLAVES-1:0]    PSLVERR,
   output logic                     TIMEOUT_EVT
);

   // A width of at least one bit keeps TIMEOUT=0 (timeout disabled) legal.
   localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   typedef enum logic [2:0] {S_IDLE, S_SETUP, S_ACCESS, S_ERR1, S_ERR2} state_t;

   state_t             r_state;
   logic [3:0]         r_sel;
   logic [PADDR_W-1:0] r_paddr;
   logic               r_pwrite;
   logic [31:0]        r_pwdata;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_tevt;

   logic               w_pready;
   logic               w_pslverr;
   logic [31:0]        w_prdata;
   logic [3:0]         w_slot;
   logic               w_slot_ok;
   logic               w_accept;
   logic               w_timeout;
   logic               w_apb_act;
   logic               w_unused;

   assign w_slot    = HADDR[SLOT_LSB+3:SLOT_LSB];
   assign w_slot_ok = ({28'd0, w_slot} < 32'(NUM_SLAVES));
   assign w_apb_act = (r_state == S_SETUP) || (r_state == S_ACCESS);
   assign w_unused  = HTRANS[0];

   // Return mux by compare so an out-of-range sel simply selects nothing.
   always_comb begin
      w_pready  = 1'b0;
      w_pslverr = 1'b0;
      w_prdata  = '0;
      for (int i = 0; i < NUM_SLAVES; i++) begin
         if (r_sel == 4'(i)) begin
            w_pready  = PREADY[i];
            w_pslverr = PSLVERR[i];
            w_prdata  = PRDATA[32*i +: 32];
         end
      end
   end

   // HREADYOUT is high only in IDLE, ERR2 and a clean ACCESS completion,
   // so it alone qualifies where an accept may be taken.
   always_comb begin
      case (r_state)
         S_SETUP, S_ERR1: HREADYOUT = 1'b0;
         S_ACCESS:        HREADYOUT = w_pready & ~w_pslverr;
         default:         HREADYOUT = 1'b1;
      endcase
   end

   assign w_accept  = HSEL & HREADYIN & HTRANS[1] & HREADYOUT;
   assign w_timeout = (TIMEOUT != 0) && !w_pready && (r_cnt == CNT_LAST);

   // One-hot PSEL decoded from the registered state and slot.
   always_comb begin
      PSEL = '0;
      for (int i = 0; i < NUM_SLAVES; i++) begin
         PSEL[i] = w_apb_act && (r_sel == 4'(i));
      end
   end

   assign PENABLE     = (r_state == S_ACCESS);
   assign PWRITE      = r_pwrite;
   assign PADDR       = r_paddr;
   assign PWDATA      = (r_state == S_SETUP) ? HWDATA : r_pwdata;
   assign HRESP       = (r_state == S_ERR1) || (r_state == S_ERR2);
   assign HRDATA      = ((r_state == S_ACCESS) && w_pready && !w_pslverr && !r_pwrite)
                        ? w_prdata : 32'd0;
   assign TIMEOUT_EVT = r_tevt;

   // Transfer sequencing, address capture, write-data capture and wait timer.
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         r_state  <= S_IDLE;
         r_sel    <= '0;
         r_paddr  <= '0;
         r_pwrite <= 1'b0;
         r_pwdata <= '0;
         r_cnt    <= '0;
         r_tevt   <= 1'b0;
      end else begin
         r_tevt <= 1'b0;
         if (w_accept) begin
            r_sel    <= w_slot;
            r_paddr  <= HADDR[PADDR_W-1:0];
            r_pwrite <= HWRITE;
            r_state  <= w_slot_ok ? S_SETUP : S_ERR1;
         end else begin
            case (r_state)
               S_SETUP: begin
                  r_state  <= S_ACCESS;
                  r_pwdata <= HWDATA;
                  r_cnt    <= '0;
               end
               S_ACCESS: begin
                  if (w_pready) begin
                     r_state <= w_pslverr ? S_ERR1 : S_IDLE;
                  end else if (w_timeout) begin
                     r_state <= S_ERR1;
                     r_tevt  <= 1'b1;
                  end else if (r_cnt != CNT_MAX) begin
                     r_cnt <= r_cnt + CNT_W'(1);
                  end
               end
               S_ERR1:  r_state <= S_ERR2;
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ahb_apb_bridge_mp.sv
// Bench for ahb_apb_bridge_mp: reset values, a table of directed transfers,
// hand-written back-to-back/reset and out-of-range sequences, then random
// transfers checked cycle by cycle against a transfer-timeline model.
module tb_ahb_apb_bridge_mp;

   localparam int NS_A = 16;
   localparam int TO_A = 8;
   localparam int NS_B = 4;

   logic        HCLK = 1'b0;
   logic        HRESET, HSEL, HWRITE, HREADYIN;
   logic [1:0]  HTRANS;
   logic [31:0] HADDR, HWDATA;

   logic             a_hreadyout, a_hresp, a_penable, a_pwrite, a_tevt;
   logic [31:0]      a_hrdata, a_paddr, a_pwdata;
   logic [NS_A-1:0]  a_psel, a_pready, a_pslverr;
   logic [32*NS_A-1:0] a_prdata;

   logic             b_hreadyout, b_hresp, b_penable, b_pwrite, b_tevt;
   logic [31:0]      b_hrdata, b_paddr, b_pwdata;
   logic [NS_B-1:0]  b_psel, b_pready, b_pslverr;
   logic [32*NS_B-1:0] b_prdata;

   int n_chk = 0;
   int n_fail = 0;
   bit mon_en = 1'b0;

   always #5 HCLK = ~HCLK;

   ahb_apb_bridge_mp #(.NUM_SLAVES(NS_A), .SLOT_LSB(8), .PADDR_W(32), .TIMEOUT(TO_A)) u_dut_a (
      .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HTRANS(HTRANS), .HWRITE(HWRITE),
      .HADDR(HADDR), .HWDATA(HWDATA), .HREADYIN(HREADYIN),
      .HREADYOUT(a_hreadyout), .HRESP(a_hresp), .HRDATA(a_hrdata),
      .PSEL(a_psel), .PENABLE(a_penable), .PWRITE(a_pwrite), .PADDR(a_paddr), .PWDATA(a_pwdata),
      .PRDATA(a_prdata), .PREADY(a_pready), .PSLVERR(a_pslverr), .TIMEOUT_EVT(a_tevt));

   ahb_apb_bridge_mp #(.NUM_SLAVES(NS_B)) u_dut_b (
      .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HTRANS(HTRANS), .HWRITE(HWRITE),
      .HADDR(HADDR), .HWDATA(HWDATA), .HREADYIN(HREADYIN),
      .HREADYOUT(b_hreadyout), .HRESP(b_hresp), .HRDATA(b_hrdata),
      .PSEL(b_psel), .PENABLE(b_penable), .PWRITE(b_pwrite), .PADDR(b_paddr), .PWDATA(b_pwdata),
      .PRDATA(b_prdata), .PREADY(b_pready), .PSLVERR(b_pslverr), .TIMEOUT_EVT(b_tevt));

   typedef struct {
      logic [31:0] addr;
      logic        wr;
      logic [31:0] wdata;
      int          waits;
      logic        err;
      logic [31:0] rdata;
      int          e_low;
      logic        e_hresp;
      logic [31:0] e_hrdata;
      logic [15:0] e_psel;
      int          e_tevt;
   } vec_t;

   task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge HCLK);
      #1;
   endtask

   task automatic rand_prdata();
      for (int i = 0; i < NS_A; i++) a_prdata[32*i +: 32] = $urandom;
   endtask

   // Bus-wide invariants: at most one PSEL, PENABLE only alongside a PSEL.
   always @(negedge HCLK) begin
      if (mon_en) begin
         check("mon_a_psel", {95'd0, ($countones(a_psel) <= 1) && (!a_penable || (a_psel != '0))}, 96'd1);
         check("mon_b_psel", {95'd0, ($countones(b_psel) <= 1) && (!b_penable || (b_psel != '0))}, 96'd1);
      end
   end

   // Non-accepting cycle: unselected, IDLE/BUSY, or HREADYIN low.
   task automatic idle_cyc(input string tag);
      int r;
      tick();
      r        = $urandom_range(0, 2);
      HSEL     = (r != 0);
      HTRANS   = (r == 2) ? 2'b10 : 2'($urandom_range(0, 3));
      if (r == 1) HTRANS[1] = 1'b0;
      HREADYIN = (r != 2);
      HADDR    = $urandom;
      HWRITE   = 1'($urandom);
      HWDATA   = $urandom;
      a_pready = 16'($urandom);
      a_pslverr = 16'($urandom);
      @(negedge HCLK);
      check(tag, {a_psel, a_penable, a_hreadyout, a_hresp, a_tevt, a_hrdata},
            {16'h0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0});
   endtask

   // One transfer on instance A from IDLE. The slave plan (waits, err) fixes
   // the whole timeline: SETUP, nacc ACCESS cycles, then either completion or
   // the two ERROR cycles.
   task automatic run_xfer(input string tag, input logic [31:0] addr, input logic wr,
                           input logic [31:0] wdata, input int waits, input logic err,
                           input logic [31:0] rdata, output int o_low, output logic o_hresp,
                           output logic [31:0] o_hrdata, output logic [15:0] o_psel,
                           output int o_tevt);
      int slot, nacc, kend;
      bit tmo, bad;
      logic [15:0] e_psel;
      logic        e_pen, e_hro, e_hresp, e_tevt;
      logic [31:0] e_hrd;
      slot = int'(addr[11:8]);
      tmo  = (waits >= TO_A);
      bad  = tmo || err;
      nacc = tmo ? TO_A : waits + 1;
      kend = bad ? nacc + 3 : nacc + 1;
      o_low = 0; o_tevt = 0; o_psel = '0; o_hresp = 1'b0; o_hrdata = '0;
      tick();
      HSEL = 1'b1; HTRANS = 2'b10; HWRITE = wr; HADDR = addr; HREADYIN = 1'b1;
      HWDATA = $urandom; a_pready = 16'($urandom); a_pslverr = 16'($urandom);
      rand_prdata();
      @(negedge HCLK);
      check({tag, "_accept"}, {a_hreadyout, a_hresp, a_psel}, {1'b1, 1'b0, 16'h0});
      for (int k = 1; k <= kend; k++) begin
         tick();
         HSEL   = 1'($urandom);
         HTRANS = 2'($urandom_range(0, 1));
         HREADYIN = 1'b1;
         HWDATA = wdata;
         a_pready  = 16'($urandom);
         a_pslverr = 16'($urandom);
         rand_prdata();
         a_prdata[32*slot +: 32] = rdata;
         a_pready[slot]  = (k == nacc + 1) && !tmo;
         a_pslverr[slot] = (k == nacc + 1) && !tmo && err;
         e_psel  = (k <= nacc + 1) ? (16'h1 << slot) : 16'h0;
         e_pen   = (k >= 2) && (k <= nacc + 1);
         e_hro   = (k == kend);
         e_hresp = bad && (k >= nacc + 2);
         e_tevt  = tmo && (k == nacc + 2);
         e_hrd   = (!bad && !wr && (k == kend)) ? rdata : 32'h0;
         @(negedge HCLK);
         check($sformatf("%s_k%0d_ctl", tag, k), {a_psel, a_penable, a_hreadyout, a_hresp, a_tevt},
               {e_psel, e_pen, e_hro, e_hresp, e_tevt});
         check($sformatf("%s_k%0d_hrdata", tag, k), {64'd0, a_hrdata}, {64'd0, e_hrd});
         if (k <= nacc + 1)
            check($sformatf("%s_k%0d_apb", tag, k), {a_paddr, a_pwrite, a_pwdata}, {addr, wr, wdata});
         if (!a_hreadyout) o_low++;
         if (a_tevt) o_tevt++;
         if (k == 1) o_psel = a_psel;
         if (k == kend) begin
            o_hresp  = a_hresp;
            o_hrdata = a_hrdata;
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t        tbl [8];
      int          o_low, o_tevt;
      logic        o_hresp;
      logic [31:0] o_hrdata, r, addr;
      logic [15:0] o_psel;

      tbl[0] = '{32'h0000_0304, 1'b1, 32'hA5A5_0001, 0,  1'b0, 32'h1111_2222, 1,  1'b0, 32'h0,         16'h0008, 0};
      tbl[1] = '{32'h0000_0200, 1'b0, 32'h0,         3,  1'b0, 32'hDEAD_BEEF, 4,  1'b0, 32'hDEAD_BEEF, 16'h0004, 0};
      tbl[2] = '{32'h0000_0100, 1'b0, 32'h0,         0,  1'b1, 32'hCAFE_0001, 3,  1'b1, 32'h0,         16'h0002, 0};
      tbl[3] = '{32'h0000_0040, 1'b0, 32'h0,         20, 1'b0, 32'h5555_AAAA, 10, 1'b1, 32'h0,         16'h0001, 1};
      tbl[4] = '{32'h0000_0F7C, 1'b0, 32'h0,         7,  1'b0, 32'h1234_5678, 8,  1'b0, 32'h1234_5678, 16'h8000, 0};
      tbl[5] = '{32'h0000_0908, 1'b1, 32'h0BAD_F00D, 8,  1'b0, 32'h0,         10, 1'b1, 32'h0,         16'h0200, 1};
      tbl[6] = '{32'h0000_0634, 1'b1, 32'h7777_0006, 2,  1'b1, 32'h0,         5,  1'b1, 32'h0,         16'h0040, 0};
      tbl[7] = '{32'hFFFF_FC10, 1'b1, 32'h0123_4567, 1,  1'b0, 32'h0,         2,  1'b0, 32'h0,         16'h1000, 0};

      HRESET = 1'b1; HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HADDR = '0; HWDATA = '0;
      HREADYIN = 1'b1; a_pready = '0; a_pslverr = '0; a_prdata = '0;
      b_pready = '1; b_pslverr = '0;
      for (int i = 0; i < NS_B; i++) b_prdata[32*i +: 32] = 32'h0B0B_0000 + 32'(i);

      // Reset values
      repeat (2) tick();
      @(negedge HCLK);
      check("rst_ctl", {a_psel, a_penable, a_pwrite, a_hreadyout, a_hresp, a_tevt},
            {16'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
      check("rst_paddr_pwdata", {a_paddr, a_pwdata, a_hrdata}, 96'h0);
      check("rst_b", {b_psel, b_penable, b_hreadyout, b_hresp}, {4'h0, 1'b0, 1'b1, 1'b0});
      tick();
      HRESET = 1'b0;
      mon_en = 1'b1;
      idle_cyc("idle0");

      // Directed table
      for (int i = 0; i < 8; i++) begin
         run_xfer($sformatf("tbl%0d", i), tbl[i].addr, tbl[i].wr, tbl[i].wdata, tbl[i].waits,
                  tbl[i].err, tbl[i].rdata, o_low, o_hresp, o_hrdata, o_psel, o_tevt);
         check($sformatf("tbl%0d_low_cycles", i), 96'(o_low), 96'(tbl[i].e_low));
         check($sformatf("tbl%0d_final_resp", i), {o_hresp, o_hrdata}, {tbl[i].e_hresp, tbl[i].e_hrdata});
         check($sformatf("tbl%0d_setup_psel", i), {80'd0, o_psel}, {80'd0, tbl[i].e_psel});
         check($sformatf("tbl%0d_tevt_pulses", i), 96'(o_tevt), 96'(tbl[i].e_tevt));
         idle_cyc($sformatf("tbl%0d_idle", i));
      end

      // Back-to-back writes to slots 0 and 5, reset during the second ACCESS
      a_pready = '1; a_pslverr = '0;
      tick();
      HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'h0000_0010; HREADYIN = 1'b1;
      a_pready = '1; a_pslverr = '0;
      @(negedge HCLK);
      check("b2b_accept0", {95'd0, a_hreadyout}, 96'd1);
      tick();
      HSEL = 1'b0; HTRANS = 2'b00; HWDATA = 32'h1000_0000;
      @(negedge HCLK);
      check("b2b_setup0", {a_psel, a_penable, a_hreadyout}, {16'h0001, 1'b0, 1'b0});
      tick();
      HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'h0000_0520;
      @(negedge HCLK);
      check("b2b_access0", {a_psel, a_penable, a_hreadyout, a_pwdata},
            {16'h0001, 1'b1, 1'b1, 32'h1000_0000});
      tick();
      HSEL = 1'b0; HTRANS = 2'b00; HWDATA = 32'h5000_0005;
      @(negedge HCLK);
      check("b2b_setup5", {a_psel, a_penable, a_hreadyout, a_paddr, a_pwdata},
            {16'h0020, 1'b0, 1'b0, 32'h0000_0520, 32'h5000_0005});
      tick();
      HRESET = 1'b1;
      @(negedge HCLK);
      check("b2b_access5", {a_psel, a_penable}, {16'h0020, 1'b1});
      tick();
      HRESET = 1'b0;
      @(negedge HCLK);
      check("b2b_after_reset", {a_psel, a_penable, a_pwrite, a_paddr, a_pwdata, a_hreadyout, a_hresp, a_tevt},
            {16'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0});
      tick();
      @(negedge HCLK);
      check("b2b_no_error", {a_psel, a_hreadyout, a_hresp}, {16'h0, 1'b1, 1'b0});

      // Out-of-range slot on the 4-slot instance
      tick();
      HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = 32'h0000_0700;
      @(negedge HCLK);
      check("oor_accept", {b_psel, b_hreadyout, b_hresp}, {4'h0, 1'b1, 1'b0});
      tick();
      HSEL = 1'b0; HTRANS = 2'b00;
      @(negedge HCLK);
      check("oor_err1", {b_psel, b_penable, b_hreadyout, b_hresp}, {4'h0, 1'b0, 1'b0, 1'b1});
      tick();
      @(negedge HCLK);
      check("oor_err2", {b_psel, b_penable, b_hreadyout, b_hresp}, {4'h0, 1'b0, 1'b1, 1'b1});
      tick();
      @(negedge HCLK);
      check("oor_idle", {b_psel, b_penable, b_hreadyout, b_hresp}, {4'h0, 1'b0, 1'b1, 1'b0});

      // Random transfers against the timeline model
      for (int n = 0; n < 40; n++) begin
         r    = $urandom;
         addr = {r[31:12], 4'($urandom_range(0, 15)), r[7:0]};
         run_xfer($sformatf("rnd%0d", n), addr, 1'($urandom), $urandom, $urandom_range(0, 10),
                  ($urandom_range(0, 3) == 0), $urandom, o_low, o_hresp, o_hrdata, o_psel, o_tevt);
         repeat ($urandom_range(1, 3)) idle_cyc($sformatf("rnd%0d_idle", n));
      end

      mon_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
